// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of independently programmable square-wave clock dividers
// Optional macro CLK_DIV_BANK_ALIGN_EN adds an align input that restarts every channel phase.
module clk_div_bank #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 26,
  parameter int HALF_INIT = 20,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
`ifdef CLK_DIV_BANK_ALIGN_EN
  input  logic              align,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(HALF_INIT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  half_d [NUM_CH];
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              accept, ch_ok, align_w;

`ifdef CLK_DIV_BANK_ALIGN_EN
  assign align_w = align;
`else
  assign align_w = 1'b0;
`endif

  // Half-periods of 0 and 1 both mean "toggle every enabled cycle".
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - ONE;
  endfunction

  assign accept = cfg_valid && cfg_ready_q;
  assign ch_ok  = 32'(cfg_ch) < 32'(NUM_CH);

  always_comb begin
    cfg_ready_d = !accept;
    cfg_err_d   = accept && !ch_ok;
    wr_hit      = '0;
    clk_out_d   = clk_out_q;
    tick_d      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      wr_hit[i] = accept && ch_ok && (32'(cfg_ch) == 32'(i));
      if (wr_hit[i]) begin
        half_d[i] = cfg_half;
      end
      // Align beats everything; a write beats its channel's terminal count.
      if (align_w) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (wr_hit[i]) begin
        cnt_d[i] = '0;
      end else if (en[i]) begin
        if (cnt_q[i] == last_cnt(half_q[i])) begin
          cnt_d[i]     = '0;
          clk_out_d[i] = ~clk_out_q[i];
          tick_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        half_q[i] <= HALF_RST;
      end
      clk_out_q   <= '0;
      tick_q      <= '0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule
